// File: rtl/divider_restoring.sv
// Fixed-point Q8.7 signed divider: sign-magnitude restoring division, one quotient
// bit per clock, rounded half away from zero with saturation and divide-by-zero reporting.
module divider_restoring (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] dividend,
   input  logic [15:0] divisor,
   input  logic        start,
   output logic [15:0] result,
   output logic        overflow_flag,
   output logic        div_by_zero,
   output logic        finish,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CALC  = 2'd1,
      FINAL = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [23:0] num_q, num_d;
   logic [15:0] dvs_q, dvs_d;
   logic        sign_q, sign_d;
   logic        dvd_neg_q, dvd_neg_d;
   logic [16:0] rem_q, rem_d;
   logic [23:0] quo_q, quo_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [15:0] result_q, result_d;
   logic        ovf_q, ovf_d;
   logic        dbz_q, dbz_d;
   logic        finish_q, finish_d;
   logic        busy_q, busy_d;

   logic [17:0] trial_s;
   logic        ge_s;
   logic [23:0] m_s;

   function automatic logic [15:0] mag16(input logic [15:0] v);
      mag16 = v[15] ? 16'(~v + 16'd1) : v;
   endfunction

   assign trial_s = {rem_q, num_q[23]};
   assign ge_s    = (trial_s >= {2'b00, dvs_q});
   // Rounded magnitude: the quotient carries one extra fraction bit for rounding.
   assign m_s     = 24'(({1'b0, quo_q} + 25'd1) >> 1);

   // Next-state, datapath and output-register logic.
   always_comb begin
      state_d   = state_q;
      num_d     = num_q;
      dvs_d     = dvs_q;
      sign_d    = sign_q;
      dvd_neg_d = dvd_neg_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      cnt_d     = cnt_q;
      result_d  = result_q;
      ovf_d     = ovf_q;
      dbz_d     = dbz_q;
      finish_d  = finish_q;
      busy_d    = busy_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               num_d     = {mag16(dividend), 8'd0};
               dvs_d     = mag16(divisor);
               sign_d    = dividend[15] ^ divisor[15];
               dvd_neg_d = dividend[15];
               rem_d     = 17'd0;
               quo_d     = 24'd0;
               cnt_d     = 5'd0;
               finish_d  = 1'b0;
               busy_d    = 1'b1;
               state_d   = CALC;
            end else begin
               state_d = IDLE;
            end
         end
         CALC: begin
            num_d = {num_q[22:0], 1'b0};
            rem_d = ge_s ? 17'(trial_s - {2'b00, dvs_q}) : trial_s[16:0];
            quo_d = {quo_q[22:0], ge_s};
            cnt_d = 5'(cnt_q + 5'd1);
            if (cnt_q == 5'd23) begin
               state_d = FINAL;
            end else begin
               state_d = CALC;
            end
         end
         FINAL: begin
            dbz_d = 1'b0;
            ovf_d = 1'b0;
            if (dvs_q == 16'd0) begin
               dbz_d    = 1'b1;
               ovf_d    = 1'b1;
               result_d = dvd_neg_q ? 16'h8000 : 16'h7FFF;
            end else if (m_s == 24'd0) begin
               result_d = 16'h0000;
            end else if (!sign_q) begin
               if (m_s > 24'd32767) begin
                  result_d = 16'h7FFF;
                  ovf_d    = 1'b1;
               end else begin
                  result_d = m_s[15:0];
               end
            end else begin
               // -32768 is representable, so only magnitudes beyond it saturate.
               if (m_s > 24'd32768) begin
                  result_d = 16'h8000;
                  ovf_d    = 1'b1;
               end else begin
                  result_d = 16'(~m_s[15:0] + 16'd1);
               end
            end
            finish_d = 1'b1;
            busy_d   = 1'b0;
            state_d  = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         num_q     <= 24'd0;
         dvs_q     <= 16'd0;
         sign_q    <= 1'b0;
         dvd_neg_q <= 1'b0;
         rem_q     <= 17'd0;
         quo_q     <= 24'd0;
         cnt_q     <= 5'd0;
         result_q  <= 16'd0;
         ovf_q     <= 1'b0;
         dbz_q     <= 1'b0;
         finish_q  <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         num_q     <= num_d;
         dvs_q     <= dvs_d;
         sign_q    <= sign_d;
         dvd_neg_q <= dvd_neg_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         cnt_q     <= cnt_d;
         result_q  <= result_d;
         ovf_q     <= ovf_d;
         dbz_q     <= dbz_d;
         finish_q  <= finish_d;
         busy_q    <= busy_d;
      end
   end

   assign result        = result_q;
   assign overflow_flag = ovf_q;
   assign div_by_zero   = dbz_q;
   assign finish        = finish_q;
   assign busy          = busy_q;

endmodule

// File: tb/tb_divider_restoring.sv
// Directed self-checking bench for divider_restoring with hand-computed Q8.7 quotients.
module tb_divider_restoring;

   logic        clk;
   logic        rst;
   logic [15:0] dividend;
   logic [15:0] divisor;
   logic        start;
   logic [15:0] result;
   logic        overflow_flag;
   logic        div_by_zero;
   logic        finish;
   logic        busy;

   int n_checks = 0;
   int n_err    = 0;

   divider_restoring dut (
      .clk           (clk),
      .rst           (rst),
      .dividend      (dividend),
      .divisor       (divisor),
      .start         (start),
      .result        (result),
      .overflow_flag (overflow_flag),
      .div_by_zero   (div_by_zero),
      .finish        (finish),
      .busy          (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Wait for finish, counting edges since the accept edge; bounded.
   task automatic wait_finish(input int inject_at, output int cycles);
      cycles = 0;
      while (finish !== 1'b1 && cycles < 40) begin
         if (cycles == inject_at) begin
            start    = 1'b1;
            dividend = 16'h1234;
            divisor  = 16'h0003;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         cycles++;
      end
      start = 1'b0;
   endtask

   task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] exp_r, input logic exp_o, input logic exp_z,
                         input int inject_at);
      int cyc;
      @(negedge clk);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(posedge clk); #1;
      check({tag, ".busy_acc"}, {31'd0, busy}, 32'd1);
      check({tag, ".fin_clr"}, {31'd0, finish}, 32'd0);
      start    = 1'b0;
      dividend = 16'h5A5A;
      divisor  = 16'h0000;
      wait_finish(inject_at, cyc);
      check({tag, ".latency"}, 32'(cyc), 32'd25);
      check({tag, ".result"}, {16'd0, result}, {16'd0, exp_r});
      check({tag, ".ovf"}, {31'd0, overflow_flag}, {31'd0, exp_o});
      check({tag, ".dbz"}, {31'd0, div_by_zero}, {31'd0, exp_z});
      check({tag, ".busy_end"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      int cyc;
      int fin_seen;
      rst      = 1'b1;
      start    = 1'b0;
      dividend = 16'h0000;
      divisor  = 16'h0000;
      #1 rst = 1'b0;
      #1;
      check("rst.result", {16'd0, result}, 32'd0);
      check("rst.flags", {28'd0, overflow_flag, div_by_zero, finish, busy}, 32'd0);
      @(negedge clk);
      rst = 1'b1;

      run_op("v1_1p5_div_0p5", 16'h00C0, 16'h0040, 16'h0180, 1'b0, 1'b0, -1);
      // Outputs hold in IDLE.
      repeat (3) @(posedge clk);
      #1;
      check("hold.result", {16'd0, result}, 32'h0180);
      check("hold.finish", {31'd0, finish}, 32'd1);
      run_op("v2_neg1_div_4", 16'hFF80, 16'h0200, 16'hFFE0, 1'b0, 1'b0, -1);
      run_op("v3_1_div_3", 16'h0080, 16'h0180, 16'h002B, 1'b0, 1'b0, -1);
      run_op("v4_posovf", 16'h7FFF, 16'h0001, 16'h7FFF, 1'b1, 1'b0, -1);
      run_op("v5_min_exact", 16'h8000, 16'h0080, 16'h8000, 1'b0, 1'b0, -1);
      run_op("v6_negneg", 16'hFF40, 16'hFFC0, 16'h0180, 1'b0, 1'b0, -1);
      run_op("v7_zero_neg", 16'h0000, 16'hFF80, 16'h0000, 1'b0, 1'b0, -1);
      run_op("v8_divzero", 16'hFF00, 16'h0000, 16'h8000, 1'b1, 1'b1, -1);

      // Reset at CALC cycle 12 aborts the operation.
      @(negedge clk);
      dividend = 16'h00C0;
      divisor  = 16'h0040;
      start    = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (12) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("abort.result", {16'd0, result}, 32'd0);
      check("abort.flags", {28'd0, overflow_flag, div_by_zero, finish, busy}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      fin_seen = 0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); #1;
         if (finish === 1'b1) fin_seen++;
      end
      check("abort.no_finish", 32'(fin_seen), 32'd0);
      run_op("post_rst", 16'h0080, 16'h0180, 16'h002B, 1'b0, 1'b0, -1);

      // New start mid-operation must be ignored.
      run_op("busy_ignore", 16'h00C0, 16'h0040, 16'h0180, 1'b0, 1'b0, 9);
      repeat (3) @(posedge clk);
      #1;
      check("busy_ignore.idle", {31'd0, busy}, 32'd0);

      // start held high: second op accepted on the edge where finish is high in IDLE.
      @(negedge clk);
      dividend = 16'h00C0;
      divisor  = 16'h0040;
      start    = 1'b1;
      @(posedge clk); #1;
      dividend = 16'hFF80;
      divisor  = 16'h0200;
      cyc = 0;
      while (finish !== 1'b1 && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("b2b.lat1", 32'(cyc), 32'd25);
      check("b2b.res1", {16'd0, result}, 32'h0180);
      @(posedge clk); #1;
      check("b2b.fin_clr", {31'd0, finish}, 32'd0);
      check("b2b.busy2", {31'd0, busy}, 32'd1);
      check("b2b.res_hold", {16'd0, result}, 32'h0180);
      start = 1'b0;
      cyc = 0;
      while (finish !== 1'b1 && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("b2b.lat2", 32'(cyc), 32'd25);
      check("b2b.res2", {16'd0, result}, 32'hFFE0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
